// File: rtl/aes_pkg.sv
// Shared AES round types and GF(2^8) helpers used by the MixColumns datapath.
package aes_pkg;

    typedef logic [7:0]   byte_t;
    typedef logic [31:0]  word_t;
    typedef logic [127:0] state_t;

    localparam byte_t AES_POLY_RED = 8'h1b;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} mc_state_t;

    function automatic byte_t xtime(input byte_t x);
        return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY_RED : 8'h00);
    endfunction

    // Column c occupies state[127-32c -: 32]; column 0 is the most significant word.
    function automatic word_t get_col(input state_t s, input logic [1:0] c);
        word_t w;
        case (c)
            2'd0:    w = s[127:96];
            2'd1:    w = s[95:64];
            2'd2:    w = s[63:32];
            default: w = s[31:0];
        endcase
        return w;
    endfunction

    function automatic state_t set_col(input state_t s, input logic [1:0] c, input word_t w);
        state_t r;
        r = s;
        case (c)
            2'd0:    r[127:96] = w;
            2'd1:    r[95:64]  = w;
            2'd2:    r[63:32]  = w;
            default: r[31:0]   = w;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mix_column_fwd.sv
// Combinational forward MixColumns on one 32-bit column (row 0 in the MS byte).
module mix_column_fwd
    import aes_pkg::*;
(
    input  word_t i_col,
    output word_t o_col
);

    byte_t w_a0, w_a1, w_a2, w_a3;
    byte_t w_x0, w_x1, w_x2, w_x3;

    assign w_a0 = i_col[31:24];
    assign w_a1 = i_col[23:16];
    assign w_a2 = i_col[15:8];
    assign w_a3 = i_col[7:0];

    assign w_x0 = xtime(w_a0);
    assign w_x1 = xtime(w_a1);
    assign w_x2 = xtime(w_a2);
    assign w_x3 = xtime(w_a3);

    // 3a is formed as xtime(a) ^ a, so each row reuses the four shared xtime results.
    assign o_col[31:24] = w_x0 ^ (w_x1 ^ w_a1) ^ w_a2 ^ w_a3;
    assign o_col[23:16] = w_a0 ^ w_x1 ^ (w_x2 ^ w_a2) ^ w_a3;
    assign o_col[15:8]  = w_a0 ^ w_a1 ^ w_x2 ^ (w_x3 ^ w_a3);
    assign o_col[7:0]   = (w_x0 ^ w_a0) ^ w_a1 ^ w_a2 ^ w_x3;

endmodule

// File: rtl/mix_columns_seq.sv
// Iterative forward MixColumns: accepts one state, transforms COLS_PER_CYCLE columns per
// clock in place, then presents the result with valid/ready hold. Bypass skips the transform.
module mix_columns_seq
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_bypass,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    mc_state_t  r_state, w_state_nxt;
    logic [1:0] r_col, w_col_nxt;
    state_t     r_work, w_work_nxt;
    word_t      w_col_out [COLS_PER_CYCLE];

    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
        logic [1:0] w_idx;
        word_t      w_col_in;
        assign w_idx    = r_col + 2'(g);
        assign w_col_in = get_col(r_work, w_idx);
        mix_column_fwd u_mix_column_fwd (
            .i_col (w_col_in),
            .o_col (w_col_out[g])
        );
    end

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_work_nxt  = r_work;
        in_ready    = (r_state == IDLE) && !rst;
        out_valid   = (r_state == DONE);
        out_state   = r_work;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_work_nxt  = in_state;
                    w_col_nxt   = '0;
                    w_state_nxt = in_bypass ? DONE : BUSY;
                end
            end
            BUSY: begin
                for (int g = 0; g < COLS_PER_CYCLE; g++) begin
                    w_work_nxt = set_col(w_work_nxt, r_col + 2'(g), w_col_out[g]);
                end
                if (int'(r_col) + COLS_PER_CYCLE == 4) begin
                    w_col_nxt   = '0;
                    w_state_nxt = DONE;
                end else begin
                    w_col_nxt = r_col + 2'(COLS_PER_CYCLE);
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_col   <= '0;
            r_work  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_col   <= w_col_nxt;
            r_work  <= w_work_nxt;
        end
    end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Self-checking bench: three instances (1, 2, 4 columns per cycle) share stimulus and are
// compared against a matrix-multiply GF(2^8) model, with inverse round-trip on instance 0.
module tb_mix_columns_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [127:0] in_state;
    logic         in_bypass;
    logic         out_ready;
    logic         in_ready_w  [3];
    logic         out_valid_w [3];
    logic [127:0] out_state_w [3];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int CPC = (k == 0) ? 1 : ((k == 1) ? 2 : 4);
        mix_columns_seq #(.COLS_PER_CYCLE(CPC)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready_w[k]),
            .in_state  (in_state),
            .in_bypass (in_bypass),
            .out_valid (out_valid_w[k]),
            .out_ready (out_ready),
            .out_state (out_state_w[k])
        );
    end

    function automatic int cpc_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference model: generic shift-and-add GF(2^8) multiply reduced by x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p ^= 16'(a) << i;
        for (int i = 15; i >= 8; i--) if (p[i]) p ^= 16'h011b << (i - 8);
        return p[7:0];
    endfunction

    // Multiplies every column by the circulant matrix whose first row is coef.
    function automatic logic [127:0] circ_mul(input logic [127:0] s, input logic [31:0] coef);
        logic [127:0] r;
        logic [7:0]   acc;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = '0;
                for (int j = 0; j < 4; j++)
                    acc ^= gmul(s[127 - 32*c - 8*j -: 8], coef[31 - 8*((j - row + 4) % 4) -: 8]);
                r[127 - 32*c - 8*row -: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] mix_model(input logic [127:0] s);
        return circ_mul(s, 32'h02030101);
    endfunction

    function automatic logic [127:0] inv_mix_model(input logic [127:0] s);
        return circ_mul(s, 32'h0e0b0d09);
    endfunction

    // Entered just after a negedge with all instances idle; leaves them idle again.
    task automatic do_txn(input logic [127:0] s, input bit byp, input logic [127:0] exp, input string tag);
        bit done [3];
        int n;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s ready_idle[%0d]", tag, k), 128'(in_ready_w[k]), 128'd1);
            done[k] = 1'b0;
        end
        in_valid  = 1'b1;
        in_state  = s;
        in_bypass = byp;
        @(negedge clk);
        in_valid  = 1'b0;
        in_state  = {$urandom, $urandom, $urandom, $urandom};
        in_bypass = 1'($urandom);
        n = 1;
        while (n <= 12) begin
            for (int k = 0; k < 3; k++) begin
                if (!done[k]) begin
                    if (out_valid_w[k]) begin
                        check($sformatf("%s latency[%0d]", tag, k), 128'(n),
                              128'(byp ? 1 : 4 / cpc_of(k) + 1));
                        check($sformatf("%s data[%0d]", tag, k), out_state_w[k], exp);
                        if (k == 0 && !byp)
                            check($sformatf("%s roundtrip", tag), inv_mix_model(out_state_w[k]), s);
                        done[k] = 1'b1;
                    end else begin
                        check($sformatf("%s ready_busy[%0d]", tag, k), 128'(in_ready_w[k]), 128'd0);
                    end
                end
            end
            if (done[0] && done[1] && done[2]) break;
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 3; k++)
            if (!done[k]) check($sformatf("%s timeout[%0d]", tag, k), 128'd0, 128'd1);
        @(negedge clk);
    endtask

    localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] FIPS_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;

    initial begin
        logic [127:0] s;
        bit           byp;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_state  = '0;
        in_bypass = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst in_ready[%0d]", k), 128'(in_ready_w[k]), 128'd0);
            check($sformatf("rst out_valid[%0d]", k), 128'(out_valid_w[k]), 128'd0);
            check($sformatf("rst out_state[%0d]", k), out_state_w[k], 128'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        do_txn({32'hdb135345, 96'h0}, 1'b0, {32'h8e4da1bc, 96'h0}, "single_col");
        do_txn(FIPS_IN, 1'b0, FIPS_OUT, "fips_round1");
        do_txn({32'h01010101, 32'hc6c6c6c6, 32'hd4d4d4d5, 32'hf20a225c}, 1'b0,
               {32'h01010101, 32'hc6c6c6c6, 32'hd5d5d7d6, 32'h9fdc589d}, "fixed_xtime");
        do_txn(128'h00112233445566778899aabbccddeeff, 1'b1,
               128'h00112233445566778899aabbccddeeff, "bypass");

        // Backpressure: result must hold in DONE, then a second state follows back-to-back.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_state  = FIPS_IN;
        in_bypass = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        in_state = '0;
        repeat (4) @(negedge clk);
        for (int cyc = 0; cyc < 10; cyc++) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("hold out_valid[%0d]", k), 128'(out_valid_w[k]), 128'd1);
                check($sformatf("hold out_state[%0d]", k), out_state_w[k], FIPS_OUT);
                check($sformatf("hold in_ready[%0d]", k), 128'(in_ready_w[k]), 128'd0);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++)
            check($sformatf("release out_valid[%0d]", k), 128'(out_valid_w[k]), 128'd0);
        do_txn({32'hdb135345, 96'h0}, 1'b0, {32'h8e4da1bc, 96'h0}, "back_to_back");

        // Reset on the second BUSY cycle discards the state.
        in_valid  = 1'b1;
        in_state  = FIPS_IN;
        in_bypass = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 2; k++)
            check($sformatf("busy1 out_valid[%0d]", k), 128'(out_valid_w[k]), 128'd0);
        @(negedge clk);
        for (int k = 0; k < 2; k++)
            check($sformatf("busy2 out_valid[%0d]", k), 128'(out_valid_w[k]), 128'd0);
        rst = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("midrst out_valid[%0d]", k), 128'(out_valid_w[k]), 128'd0);
            check($sformatf("midrst out_state[%0d]", k), out_state_w[k], 128'd0);
            check($sformatf("midrst in_ready[%0d]", k), 128'(in_ready_w[k]), 128'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("postrst in_ready[%0d]", k), 128'(in_ready_w[k]), 128'd1);
            check($sformatf("postrst out_valid[%0d]", k), 128'(out_valid_w[k]), 128'd0);
            check($sformatf("postrst out_state[%0d]", k), out_state_w[k], 128'd0);
        end
        do_txn(FIPS_IN, 1'b0, FIPS_OUT, "after_rst");

        for (int i = 0; i < 1000; i++) begin
            s   = {$urandom, $urandom, $urandom, $urandom};
            byp = ($urandom_range(7) == 0);
            do_txn(s, byp, byp ? s : mix_model(s), $sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mix_columns_seq.md
Name: mix_columns_seq

Overview:
- Forward AES MixColumns engine for the AES-256 encryption datapath. It is the encrypt-side counterpart of the decryption-side inverse MixColumns column helper.
- Accepts one 128-bit round state through a valid/ready handshake and transforms it column-by-column over multiple cycles, using shared GF(2^8) xtime logic instead of lookup tables.
- Returns the result through a valid/ready output with hold.
- Sits between ShiftRows and AddRoundKey in the iterative encryption round.

Parameters:
- COLS_PER_CYCLE, 1: columns processed per clock. Legal values are 1, 2 and 4; any other value is an elaboration error.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  input state valid
- in_ready  output  1  block can accept a state
- in_state  input  128  state; column c = in_state[127-32c -: 32], row 0 in the MS byte of each column
- in_bypass  input  1  final-round flag; pass the state unchanged (no MixColumns)
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts the result
- out_state  output  128  transformed state, same column/row layout as in_state

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high; the clock port is clk and the reset port is rst.
- Reset values: in_ready=0 during rst, 1 on the first cycle after. out_valid=0, out_state=128'h0, internal column counter=0, FSM=IDLE.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch in_state into the work register and latch in_bypass.
  - Next state is DONE if bypass=1, otherwise BUSY with col=0.
- BUSY:
  - in_ready=0.
  - Each cycle, transform COLS_PER_CYCLE columns starting at col, writing in place.
  - col increments by COLS_PER_CYCLE. When col+COLS_PER_CYCLE==4, go to DONE; col wraps to 0.
- Column transform, with column input a0..a3 and output b0..b3:
  - b0 = 2a0^3a1^a2^a3
  - b1 = a0^2a1^3a2^a3
  - b2 = a0^a1^2a2^3a3
  - b3 = 3a0^a1^a2^2a3
  - 2x = xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 8'h00)
  - 3x = xtime(x)^x
  - All arithmetic is 8-bit GF(2^8); there are no carries or widening.
- DONE:
  - out_valid=1 and out_state = work register.
  - Hold out_state stable while out_valid && !out_ready.
  - On out_ready, go to IDLE; out_valid drops the next cycle.
- Latency from an accepted input to out_valid:
  - normal: 4/COLS_PER_CYCLE + 1 cycles (5, 3 or 2)
  - bypass: 1 cycle
- Throughput: one state per latency + 1 cycles. No overlap between states; in_ready=0 in BUSY and DONE.
- in_valid asserted while in_ready=0 is ignored. The upstream block must hold it.
- in_state and in_bypass are sampled only on the accept cycle; later changes have no effect.
- Reset mid-operation (BUSY or DONE): the state is discarded with no output, and all values return to their reset values the next cycle.
- out_ready held high continuously: DONE lasts exactly one cycle.

Decomposition:
- Shared package aes_pkg holds:
  - typedef byte_t (8 bits), word_t (32 bits), state_t (128 bits)
  - constant AES_POLY_RED = 8'h1b
  - function xtime
  - enum mc_state_t {IDLE, BUSY, DONE}
- One sub-module, mix_column_fwd: a combinational 32-bit forward column transform. It is instantiated COLS_PER_CYCLE times and selected by col.

Test Plan:
- Single column, COLS_PER_CYCLE=1: in_state column 0 = 32'hdb135345, others 0 -> out column 0 = 32'h8e4da1bc, others 0, with out_valid 5 cycles after accept.
- FIPS-197 round 1, all three COLS_PER_CYCLE values: in_state 128'hd4bf5d30e0b452aeb84111f11e2798e5 -> out_state 128'h046681e5e0cb199a48f8d37a2806264c, latency 5/3/2.
- Fixed points and xtime reduction:
  - columns 32'h01010101 and 32'hc6c6c6c6 -> unchanged
  - 32'hd4d4d4d5 -> 32'hd5d5d7d6
  - 32'hf20a225c -> 32'h9fdc589d
- Bypass: in_bypass=1 with 128'h00112233445566778899aabbccddeeff -> identical out_state 1 cycle after accept; no BUSY cycles.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_state and out_valid stable and in_ready=0 throughout. Raise out_ready -> in_ready=1 the next cycle, and a back-to-back second state is accepted correctly.
- Reset mid-BUSY: assert rst on the 2nd BUSY cycle -> out_valid stays 0, out_state=0, in_ready=1 after rst deasserts. A new state then yields the correct result. Randomised bench: 1000 states checked against a C model, plus round-trip through an inverse MixColumns model to recover the input.
